text_ci_master: RTL

TEXT_CI_MASTER -- requirements
Module: text_ci_master

---
 rtl/text_ci_master.sv | 107 ++++++++++
 1 files changed

// File: rtl/text_ci_master.sv
// text_ci_master: feeds a text controller over a custom-instruction port from a filtered byte FIFO and colour strobes
module text_ci_master #(
  parameter logic [7:0] customInstructionNr = 8'd0,
  parameter int fifoDepthLog2 = 4,
  parameter int timeoutCycles = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  inData,
  input  logic        inValid,
  output logic        inReady,
  input  logic [15:0] fgColorIn,
  input  logic        fgColorWe,
  input  logic [15:0] bgColorIn,
  input  logic        bgColorWe,
  output logic [7:0]  ciN,
  output logic [31:0] ciDataA,
  output logic [31:0] ciDataB,
  output logic        ciStart,
  output logic        ciCke,
  input  logic        ciDone,
  input  logic [31:0] ciResult,
  output logic [6:0]  screenLines,
  output logic [6:0]  screenChars,
  output logic        infoValid,
  output logic        timeoutError,
  output logic        busy
);
  localparam int AW = fifoDepthLog2;
  localparam int TW = $clog2(timeoutCycles + 1);
  typedef enum logic [2:0] {INIT_ISSUE, INIT_WAIT, IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nxt;
  logic [7:0] mem [2**AW];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0] head;
  logic empty, full, push, pop, in_txn, is_init, starting, ends, finish, expire;
  logic fg_pend, bg_pend, cur_fifo, unused;
  logic [15:0] fg_val, bg_val, cur_b;
  logic [3:0] cur_op;
  logic [TW-1:0] tcnt, tcnt_nxt;
  assign unused = ^{ciResult[31:23], ciResult[15:7]};
  assign ciN = customInstructionNr;
  assign ciCke = 1'b1;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign inReady = !full;
  assign head = mem[rd_ptr[AW-1:0]];
  assign push = inValid && inReady && ((inData >= 8'h20 && inData <= 8'h7E) || inData == 8'h0A || inData == 8'h0C);
  assign in_txn = state != IDLE;
  assign is_init = state == INIT_ISSUE || state == INIT_WAIT;
  assign starting = state == INIT_ISSUE || state == ISSUE;
  assign tcnt_nxt = (starting ? '0 : tcnt) + 1'b1;
  assign expire = in_txn && !ciDone && tcnt_nxt == TW'(timeoutCycles);
  assign ends = ciDone || expire;
  assign finish = (state == ISSUE || state == WAIT) && ends;
  assign pop = finish && cur_fifo;
  assign ciStart = starting && !reset;
  assign ciDataA = (in_txn && !reset) ? {28'd0, is_init ? 4'hF : cur_op} : '0;
  assign ciDataB = (in_txn && !is_init && !reset) ? {16'd0, cur_b} : '0;
  assign busy = in_txn || !empty;
  always_comb begin
    state_nxt = state == IDLE ? ((fg_pend || bg_pend || !empty) ? ISSUE : IDLE)
              : ends ? IDLE : is_init ? INIT_WAIT : WAIT;
  end
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= inData;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT_ISSUE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fg_pend <= 1'b0;
      bg_pend <= 1'b0;
      fg_val <= '0;
      bg_val <= '0;
      cur_op <= '0;
      cur_b <= '0;
      cur_fifo <= 1'b0;
      tcnt <= '0;
      infoValid <= 1'b0;
      screenLines <= '0;
      screenChars <= '0;
      timeoutError <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      tcnt <= (in_txn && !ciDone) ? tcnt_nxt : '0;
      if (expire) timeoutError <= 1'b1;
      if (is_init && ciDone) begin
        infoValid <= 1'b1;
        screenLines <= ciResult[22:16];
        screenChars <= ciResult[6:0];
      end
      fg_pend <= fgColorWe || (fg_pend && state != IDLE);
      bg_pend <= bgColorWe || (bg_pend && !(state == IDLE && !fg_pend));
      if (fgColorWe) fg_val <= fgColorIn;
      if (bgColorWe) bg_val <= bgColorIn;
      if (state == IDLE) begin
        cur_fifo <= !fg_pend && !bg_pend;
        cur_op <= fg_pend ? 4'h0 : bg_pend ? 4'h1 : head == 8'h0C ? 4'h3 : 4'h2;
        cur_b <= fg_pend ? fg_val : bg_pend ? bg_val : head == 8'h0C ? '0 : {8'd0, head};
      end
    end
  end
endmodule
